// File: rtl/ysyx_24080006_lsu_pkg.sv
// Shared definitions for the LSU: funct3 codes, AXI responses, FSM states
// and the latched instruction payload.
package ysyx_24080006_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WRITE, WRESP, DONE
  } lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  typedef struct packed {
    logic [31:0] dnpc;
    logic [31:0] sdata;
    logic [3:0]  rd_addr;
    logic [31:0] alu_res;
    logic [2:0]  funct3;
    logic        load;
    logic        store;
    logic        wb;
    logic        jump;
    logic        branch;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic        ecall;
    logic [31:0] pc;
  } lsu_pay_t;

  // Unknown encodings on a memory op fall back to a full word.
  function automatic lsu_size_t lsu_size(input logic [2:0] f3, input logic is_store);
    lsu_size_t sz;
    sz = SZ_W;
    if (is_store) begin
      case (f3)
        F3_SB:   sz = SZ_B;
        F3_SH:   sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_B;
        F3_LH, F3_LHU: sz = SZ_H;
        default:       sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/ysyx_24080006_lsu_if.sv
// Stage-to-stage handshake bundle; prev is the receiving side, next the sending side.
interface ysyx_24080006_uif;
  logic        valid;
  logic        ready;
  logic [31:0] dnpc;
  logic [31:0] sdata;
  logic [3:0]  rd_addr;
  logic [31:0] alu_res;
  logic [2:0]  funct3;
  logic        load;
  logic        store;
  logic        wb;
  logic        jump;
  logic        branch;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        ecall;
  logic [31:0] pc;
  logic [31:0] wb_data;
  logic        mem_err;

  modport prev (
    input  valid, dnpc, sdata, rd_addr, alu_res, funct3, load, store, wb, jump,
           branch, csr_addr, csr_we, csr_wdata, ecall, pc,
    output ready
  );

  modport next (
    output valid, dnpc, sdata, rd_addr, alu_res, funct3, load, store, wb, jump,
           branch, csr_addr, csr_we, csr_wdata, ecall, pc, wb_data, mem_err,
    input  ready
  );
endinterface

// File: rtl/ysyx_24080006_lsu_align.sv
// Byte-lane steering: store strobes/replication, load extraction, misalignment.
module ysyx_24080006_lsu_align
  import ysyx_24080006_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  lsu_size_t   sz;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        sgn;

  assign sz = lsu_size(funct3, is_store);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wdata[8*l +: 8] = (sz == SZ_B) ? sdata[7:0] :
                             (sz == SZ_H) ? sdata[8*(l%2) +: 8] :
                                            sdata[8*l +: 8];
  end

  always_comb begin
    wstrb = 4'b1111;
    case (sz)
      SZ_B:    wstrb = 4'b0001 << addr;
      SZ_H:    wstrb = 4'b0011 << addr;
      default: wstrb = 4'b1111;
    endcase
  end

  assign misaligned = ((sz == SZ_H) && addr[0]) || ((sz == SZ_W) && (addr != 2'b00));

  // Halfword reads only reach the bus half-aligned, so addr[1] picks the half.
  assign lb  = rdata[{addr, 3'b000} +: 8];
  assign lh  = addr[1] ? rdata[31:16] : rdata[15:0];
  assign sgn = ~funct3[2];

  always_comb begin
    ld_data = rdata;
    case (sz)
      SZ_B:    ld_data = {{24{sgn & lb[7]}}, lb};
      SZ_H:    ld_data = {{16{sgn & lh[15]}}, lh};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_24080006_lsu.sv
// Load/store unit: one AXI4-Lite data access per instruction between execute and write-back.
module ysyx_24080006_lsu
  import ysyx_24080006_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  ysyx_24080006_uif.prev    exu,
  ysyx_24080006_uif.next    wbu,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  lsu_state_t  state_q, state_d;
  lsu_pay_t    pay;
  logic [31:0] wb_data_q;
  logic        mem_err_q;
  logic        aw_done, w_done;
  logic        idle, accept, mem_op;

  logic [2:0]  al_f3;
  logic        al_st;
  logic [1:0]  al_addr;
  logic [3:0]  al_strb;
  logic [31:0] al_wdata, al_ld;
  logic        al_mis;

  assign idle   = (state_q == IDLE);
  assign accept = exu.valid && idle;
  assign mem_op = exu.load || exu.store;

  // In IDLE the aligner looks at the incoming op so misalignment is known at accept.
  assign al_f3   = idle ? exu.funct3       : pay.funct3;
  assign al_st   = idle ? (exu.store && !exu.load) : (pay.store && !pay.load);
  assign al_addr = idle ? exu.alu_res[1:0] : pay.alu_res[1:0];

  ysyx_24080006_lsu_align u_align (
    .funct3     (al_f3),
    .is_store   (al_st),
    .addr       (al_addr),
    .sdata      (pay.sdata),
    .rdata      (rdata),
    .wstrb      (al_strb),
    .wdata      (al_wdata),
    .ld_data    (al_ld),
    .misaligned (al_mis)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pay       <= '0;
      wb_data_q <= '0;
      mem_err_q <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          pay.dnpc      <= exu.dnpc;
          pay.sdata     <= exu.sdata;
          pay.rd_addr   <= exu.rd_addr;
          pay.alu_res   <= exu.alu_res;
          pay.funct3    <= exu.funct3;
          pay.load      <= exu.load;
          pay.store     <= exu.store;
          pay.wb        <= exu.wb;
          pay.jump      <= exu.jump;
          pay.branch    <= exu.branch;
          pay.csr_addr  <= exu.csr_addr;
          pay.csr_we    <= exu.csr_we;
          pay.csr_wdata <= exu.csr_wdata;
          pay.ecall     <= exu.ecall;
          pay.pc        <= exu.pc;
          wb_data_q     <= exu.load ? '0 : exu.alu_res;
          mem_err_q     <= mem_op && al_mis;
          aw_done       <= 1'b0;
          w_done        <= 1'b0;
        end
        RDATA: if (rvalid) begin
          wb_data_q <= al_ld;
          mem_err_q <= (rresp != RESP_OKAY);
        end
        WRITE: begin
          if (awready) aw_done <= 1'b1;
          if (wready)  w_done  <= 1'b1;
        end
        WRESP: if (bvalid) mem_err_q <= (bresp != RESP_OKAY);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (mem_op && al_mis) state_d = DONE;
        else if (exu.load)    state_d = RADDR;
        else if (exu.store)   state_d = WRITE;
        else                  state_d = DONE;
      end
      RADDR: if (arready) state_d = RDATA;
      RDATA: if (rvalid)  state_d = DONE;
      WRITE: if ((aw_done || awready) && (w_done || wready)) state_d = WRESP;
      WRESP: if (bvalid)  state_d = DONE;
      DONE:  if (wbu.ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign araddr  = {pay.alu_res[ADDR_W-1:2], 2'b00};
  assign arvalid = (state_q == RADDR);
  assign rready  = (state_q == RDATA);
  assign awaddr  = {pay.alu_res[ADDR_W-1:2], 2'b00};
  assign awvalid = (state_q == WRITE) && !aw_done;
  assign wvalid  = (state_q == WRITE) && !w_done;
  assign wdata   = al_wdata;
  assign wstrb   = al_strb;
  assign bready  = (state_q == WRESP);

  assign exu.ready     = idle;
  assign wbu.valid     = (state_q == DONE);
  assign wbu.dnpc      = pay.dnpc;
  assign wbu.sdata     = pay.sdata;
  assign wbu.rd_addr   = pay.rd_addr;
  assign wbu.alu_res   = pay.alu_res;
  assign wbu.funct3    = pay.funct3;
  assign wbu.load      = pay.load;
  assign wbu.store     = pay.store;
  assign wbu.wb        = pay.wb;
  assign wbu.jump      = pay.jump;
  assign wbu.branch    = pay.branch;
  assign wbu.csr_addr  = pay.csr_addr;
  assign wbu.csr_we    = pay.csr_we;
  assign wbu.csr_wdata = pay.csr_wdata;
  assign wbu.ecall     = pay.ecall;
  assign wbu.pc        = pay.pc;
  assign wbu.wb_data   = wb_data_q;
  assign wbu.mem_err   = mem_err_q;

endmodule

// File: doc/ysyx_24080006_lsu.md
Name: ysyx_24080006_lsu

Overview:
- Load/store unit of the multi-cycle RV32E core, directly downstream of the execute stage and upstream of write-back.
- Takes one decoded instruction from execute: effective address in alu_res, store data in sdata, access type in funct3.
- Performs at most one AXI4-Lite data access per instruction and hands the write-back value plus pass-through control fields to write-back.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width; only 32 is supported

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high
exu  ysyx_24080006_uif.prev  -  from execute: valid/ready, dnpc, sdata, rd_addr, alu_res, funct3, load, store, wb, jump, branch, csr_addr, csr_we, csr_wdata, ecall, pc
wbu  ysyx_24080006_uif.next  -  to write-back: same fields as exu, plus wb_data[31:0] and mem_err
araddr  output  ADDR_W  read address
arvalid  output  1  read address valid
arready  input  1  read address ready
rdata  input  DATA_W  read data
rresp  input  2  read response
rvalid  input  1  read data valid
rready  output  1  read data ready
awaddr  output  ADDR_W  write address
awvalid  output  1  write address valid
awready  input  1  write address ready
wdata  output  DATA_W  write data
wstrb  output  4  write byte strobes
wvalid  output  1  write data valid
wready  input  1  write data ready
bresp  input  2  write response
bvalid  input  1  write response valid
bready  output  1  write response ready

Behaviour:
- Reset values: exu.ready=1; wbu.valid=0; all wbu payload fields=0; arvalid, rready, awvalid, wvalid, bready all 0. A reset taken mid-transaction returns the FSM to IDLE immediately. Any open bus beat is abandoned, because the whole SoC resets together.
- FSM states: IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
- IDLE:
  - Accept occurs when exu.valid && exu.ready. On accept: latch every exu field; exu.ready<=0.
  - Next state: load -> RADDR; store -> WRITE; neither -> DONE.
  - load and store both set: treat as load (decoder guarantees exclusivity).
- Misalignment: access is misaligned when a halfword has addr[0]=1, or a word has addr[1:0]!=0.
  - No bus access is issued; go straight to DONE with mem_err=1.
- RADDR: araddr={addr[31:2],2'b00}; arvalid=1 until arready seen, then -> RDATA.
- RDATA: rready=1. On rvalid: lane-extract by addr[1:0] and funct3.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - mem_err=(rresp!=0). Then -> DONE.
- WRITE:
  - awvalid and wvalid are asserted together. awaddr is word-aligned.
  - wdata = sdata replicated into lanes (SB: byte x4; SH: half x2).
  - wstrb: SB=4'b0001<<addr[1:0]; SH=4'b0011<<addr[1:0]; SW=4'b1111.
  - Each channel drops independently on its own ready. The aw_done and w_done flags must handle either order or same-cycle completion.
  - When both channels are done -> WRESP.
- WRESP: bready=1. On bvalid: mem_err=(bresp!=0), then -> DONE.
- DONE:
  - wbu.valid=1, payload held stable.
  - wb_data=load ? extracted load data : alu_res.
  - Stay in DONE until wbu.ready. Then wbu.valid<=0, exu.ready<=1 -> IDLE.
- Latency:
  - Non-memory instruction: accept in cycle N, wbu.valid in cycle N+1.
  - Load with arready and rvalid each answered in the first cycle asked: wbu.valid at N+3.
- AXI rules:
  - valid is never dropped before its ready.
  - Addresses and data are stable while valid is high.
  - Only one outstanding transaction at a time.
- funct3 encodings other than the legal load/store codes, on a memory op: treated as W.

Decomposition:
- Shared package ysyx_24080006_pkg holds:
  - funct3 constants: LB/LH/LW/LBU/LHU, SB/SH/SW.
  - AXI resp constants: OKAY=2'b00, SLVERR=2'b10.
  - The lsu_state_t enum.
- One combinational sub-module, ysyx_24080006_lsu_align. It computes wstrb/wdata from (funct3, addr[1:0], sdata), load-extract from (funct3, addr[1:0], rdata), and the misaligned flag.

Test Plan:
- Non-memory op: alu_res=0x1234, wb=1, wbu.ready=1 -> wbu.valid one cycle after accept, wb_data=0x1234, no bus activity, exu.ready back to 1.
- LB at 0x8000_0003, rdata=0x80FF_FF7F -> araddr=0x8000_0000, wb_data=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH at 0x8000_0002, sdata=0xDEAD_BEEF -> wdata=0xBEEF_BEEF, wstrb=4'b1100. Test wready before awready, then awready before wready: exactly one write each time, then bready handshake.
- LW at 0x8000_0001 -> no arvalid ever raised; wbu.valid with mem_err=1.
- Load with rresp=SLVERR, arready delayed 3 cycles, wbu.ready held low 4 cycles -> arvalid and araddr stable while waiting; mem_err=1; wbu payload stable until ready.
- Reset asserted in RDATA -> next cycle all outputs at reset values, exu.ready=1; a fresh non-memory op then completes normally.
